joy_db15_tx: RTL and testbench
==============================

// Module: joy_db15_tx
// PURPOSE
// - Responder end of the SNAC DB15 serial joystick link: emulates the adapter's parallel-in/serial-out shifter.
// - Serves two 16-bit joystick words to a joy_db15 master driving JOY_LOAD/JOY_CLK.
// - Used for loopback verification of joy_db15 and for SNAC pass-through/slave builds; sits beside joy_db15 on USER_IN/USER_OUT.
// PARAMETERS
// - FRAME_BITS      32        bits per frame: joystick1[15:0] then joystick2[15:0], MSB first
// - SYNC_STAGES     2         synchronizer flops on JOY_CLK and JOY_LOAD (>=2)
// - IDLE_LEVEL      1'b1      JOY_DATA level outside a frame
// - TIMEOUT_CYCLES  2680000   link-lost watchdog, clk cycles (50 ms at 53.6 MHz); used only with macro
// PORTS
// - clk         in   1   system clock (53.6 MHz domain)
// - reset       in   1   synchronous, active-high
// - joystick1   in   16  P1 buttons, active-high (1 = pressed), joy_db15 bit order
// - joystick2   in   16  P2 buttons, active-high
// - JOY_CLK     in   1   async shift clock from master; rising edge advances one bit
// - JOY_LOAD    in   1   async load from master; rising edge latches the parallel words
// - JOY_DATA    out  1   serial data, active-low on wire (0 = pressed)
// - frame_done  out  1   one-cycle pulse: full frame shifted out
// - frame_err   out  1   one-cycle pulse: short frame or overrun clock
// - link_lost   out  1   sticky, set on watchdog expiry (tied 0 without macro)
// BEHAVIOUR
// - Reset: JOY_DATA=IDLE_LEVEL, frame_done=0, frame_err=0, link_lost=0, state=IDLE, count=0, shreg=all 1s.
// - JOY_CLK/JOY_LOAD pass through SYNC_STAGES flops plus one edge-detect flop.
// - Pin edge to JOY_DATA change: SYNC_STAGES+1 clk cycles. Master holds each phase >= SYNC_STAGES+2 cycles.
// - States: IDLE, SHIFT, DONE.
// - Load edge, any state:
//   - shreg <= ~{joystick1, joystick2}; JOY_DATA <= ~joystick1[15]; count <= 0; state -> SHIFT.
// - Clk edge in SHIFT, JOY_LOAD low:
//   - shreg <= {shreg[FRAME_BITS-2:0], 1'b1}; count <= count+1.
//   - JOY_DATA follows shreg MSB (new bit).
//   - When the edge makes count == FRAME_BITS: state -> DONE, JOY_DATA <= IDLE_LEVEL, frame_done pulses one cycle.
// - count width is $clog2(FRAME_BITS+1); it never wraps: DONE is entered at FRAME_BITS.
// - Boundary cases:
//   - Clk edge while synchronized JOY_LOAD high: ignored (load dominates).
//   - Load and clk edge in the same cycle: load wins; clk dropped; no error.
//   - Load edge in SHIFT with 0 < count < FRAME_BITS: frame_err pulses; the new capture proceeds.
//   - Load edge in SHIFT with count == 0: no error.
//   - Clk edge in DONE: frame_err pulses; JOY_DATA stays IDLE_LEVEL; state stays DONE.
//   - Clk edge in IDLE: ignored, no error.
//   - Inputs change mid-frame: no effect until the next load edge (snapshot semantics).
//   - reset mid-frame: immediate return to reset values, including JOY_DATA.
// CONFIGURATION
// - Macro: JOY_DB15_TX_TIMEOUT_EN.
// - Defined:
//   - Free-running counter cleared by every load edge.
//   - On reaching TIMEOUT_CYCLES: link_lost <= 1 (sticky), state -> IDLE, JOY_DATA <= IDLE_LEVEL.
//   - link_lost clears only on reset or on the next load edge.
// - Undefined: counter not built; link_lost is constant 0.
// TESTING
// - Capture, 4 cycles/phase: joystick1=16'h0011, joystick2=16'h8000, load pulse + 32 clks
//   -> JOY_DATA reads ~{16'h0011,16'h8000} = 32'hFFEE_7FFF MSB first; frame_done once after clk 32; frame_err never.
// - Snapshot: change joystick1 to 16'hFFFF after clk 5 -> remaining bits still from 16'h0011; next frame shows 16'hFFFF.
// - Short frame: load, 10 clks, load -> frame_err one pulse at second load; next frame complete and correct; frame_done once.
// - Overrun: full frame, then 3 extra clks -> 3 frame_err pulses; JOY_DATA held at 1.
// - Collision: load and clk rise on the same clk edge -> no shift; first bit is ~joystick1[15]; no frame_err.
// - Reset after clk 12 -> JOY_DATA=1 next cycle; following load/32-clk frame is correct.
// - Macro defined, TIMEOUT_CYCLES=1000, no load for 1000 cycles -> link_lost=1; next load clears it.
// - Macro undefined, same stimulus -> link_lost stays 0.

Source files
------------

// File: rtl/joy_db15_tx_if.sv
// ---------------------------------------------------------------------------
// joy_db15_tx_if
// Purpose : the three wires of the SNAC DB15 serial joystick link.
// Signals :
//   JOY_CLK   shift clock, driven by the master (joy_db15)
//   JOY_LOAD  parallel-load strobe, driven by the master
//   JOY_DATA  serial data, driven by the responder (joy_db15_tx), active-low
// Modports:
//   master  drives JOY_CLK/JOY_LOAD, samples JOY_DATA
//   slave   samples JOY_CLK/JOY_LOAD, drives JOY_DATA
// Handshake: there is no valid/ready pair on this link. The master owns all
//   timing. A rising JOY_LOAD captures a frame. Each rising JOY_CLK then
//   advances one bit. Each phase is held long enough for the responder's
//   synchronizers to see it.
// ---------------------------------------------------------------------------
interface joy_db15_tx_if;
  logic JOY_CLK;
  logic JOY_LOAD;
  logic JOY_DATA;

  modport master (output JOY_CLK, output JOY_LOAD, input JOY_DATA);
  modport slave  (input JOY_CLK, input JOY_LOAD, output JOY_DATA);
endinterface

// File: rtl/joy_db15_tx.sv
// ---------------------------------------------------------------------------
// joy_db15_tx
// Purpose : responder end of the SNAC DB15 serial joystick link. It emulates
//   the adapter's parallel-in/serial-out shifter. A frame is joystick1[15:0]
//   then joystick2[15:0], sent MSB first, inverted on the wire
//   (0 = pressed).
// Optional feature: define JOY_DB15_TX_TIMEOUT_EN to build the link-lost
//   watchdog. Without it, link_lost is tied to 0.
// Ports :
//   clk, reset            system clock; synchronous active-high reset
//   joystick1, joystick2  button words, active-high, captured on load
//   joy (slave)           JOY_CLK / JOY_LOAD inputs (async), JOY_DATA output
//   frame_done            1-cycle pulse when the last bit has been shifted
//   frame_err             1-cycle pulse on a short frame or an overrun clock
//   link_lost             sticky watchdog flag
//   dbg_state             current FSM state (0 IDLE, 1 SHIFT, 2 DONE)
// Timing: a pin edge reaches JOY_DATA SYNC_STAGES+1 clk cycles later.
// ---------------------------------------------------------------------------
module joy_db15_tx #(
  parameter int   FRAME_BITS     = 32,
  parameter int   SYNC_STAGES    = 2,
  parameter logic IDLE_LEVEL     = 1'b1,
  parameter int   TIMEOUT_CYCLES = 2680000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   joystick1,
  input  logic [15:0]   joystick2,
  joy_db15_tx_if.slave  joy,
  output logic          frame_done,
  output logic          frame_err,
  output logic          link_lost,
  output logic [1:0]    dbg_state
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_count;
  logic [FRAME_BITS-1:0]   r_shreg;
  logic                    r_data;
  logic                    r_frame_done;
  logic                    r_frame_err;

  logic [SYNC_STAGES-1:0]  r_clk_sync;
  logic [SYNC_STAGES-1:0]  r_load_sync;
  logic                    r_clk_prev;
  logic                    r_load_prev;

  logic                    w_clk_lvl;
  logic                    w_load_lvl;
  logic                    w_clk_rise;
  logic                    w_load_rise;
  logic [CNT_W-1:0]        w_count_nxt;
  logic                    w_timeout;

  // Synchronizers plus one edge-detect flop per input.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_sync  <= '0;
      r_load_sync <= '0;
      r_clk_prev  <= 1'b0;
      r_load_prev <= 1'b0;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], joy.JOY_CLK};
      r_load_sync <= {r_load_sync[SYNC_STAGES-2:0], joy.JOY_LOAD};
      r_clk_prev  <= w_clk_lvl;
      r_load_prev <= w_load_lvl;
    end
  end

  assign w_clk_lvl   = r_clk_sync[SYNC_STAGES-1];
  assign w_load_lvl  = r_load_sync[SYNC_STAGES-1];
  assign w_clk_rise  = w_clk_lvl & ~r_clk_prev;
  assign w_load_rise = w_load_lvl & ~r_load_prev;
  assign w_count_nxt = r_count + 1'b1;

`ifdef JOY_DB15_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] r_wd;
  logic            r_link_lost;

  // The counter saturates at TIMEOUT_CYCLES, so w_timeout fires exactly once
  // for each silent period. A load edge restarts the counter.
  assign w_timeout = (r_wd == WD_W'(TIMEOUT_CYCLES - 1)) && !w_load_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wd        <= '0;
      r_link_lost <= 1'b0;
    end else if (w_load_rise) begin
      r_wd        <= '0;
      r_link_lost <= 1'b0;
    end else begin
      if (r_wd != WD_W'(TIMEOUT_CYCLES))
        r_wd <= r_wd + 1'b1;
      if (w_timeout)
        r_link_lost <= 1'b1;
    end
  end

  assign link_lost = r_link_lost;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
  assign w_timeout        = 1'b0;
  assign link_lost        = 1'b0;
`endif

  // Main FSM. The priority is: load edge, then watchdog, then clock edge.
  // A clock edge is dropped while the synchronized load is high. This also
  // covers a load edge and a clock edge in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_shreg      <= '1;
      r_data       <= IDLE_LEVEL;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_load_rise) begin
        // A load with bits already shifted means the previous frame was cut short.
        if (r_state == SHIFT && r_count != '0)
          r_frame_err <= 1'b1;
        r_shreg <= ~{joystick1, joystick2};
        r_data  <= ~joystick1[15];
        r_count <= '0;
        r_state <= SHIFT;
      end else if (w_timeout) begin
        r_state <= IDLE;
        r_data  <= IDLE_LEVEL;
      end else if (w_clk_rise && !w_load_lvl) begin
        case (r_state)
          SHIFT: begin
            r_shreg <= {r_shreg[FRAME_BITS-2:0], 1'b1};
            r_count <= w_count_nxt;
            if (w_count_nxt == CNT_W'(FRAME_BITS)) begin
              r_state      <= DONE;
              r_data       <= IDLE_LEVEL;
              r_frame_done <= 1'b1;
            end else begin
              // The new MSB after this shift.
              r_data <= r_shreg[FRAME_BITS-2];
            end
          end
          DONE: begin
            // A clock edge after the frame is complete is an overrun.
            r_frame_err <= 1'b1;
            r_data      <= IDLE_LEVEL;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign joy.JOY_DATA = r_data;
  assign frame_done   = r_frame_done;
  assign frame_err    = r_frame_err;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_joy_db15_tx.sv
// ---------------------------------------------------------------------------
// tb_joy_db15_tx
// Purpose : directed bench for joy_db15_tx. A table of joystick words and
//   hand-computed wire frames is applied in a loop. Hand-written sequences
//   cover snapshot, short frame, overrun, collision, reset and watchdog.
// Build with or without JOY_DB15_TX_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_joy_db15_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] j1;
  logic [15:0] j2;
  logic        frame_done;
  logic        frame_err;
  logic        link_lost;
  logic [1:0]  dbg_state;

  joy_db15_tx_if u_if();

  joy_db15_tx #(.TIMEOUT_CYCLES(1000)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .joystick1  (j1),
    .joystick2  (j2),
    .joy        (u_if.slave),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .link_lost  (link_lost),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  logic [31:0] exp_q[$];

  // Pulse counters.
  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (frame_err)  err_cnt++;
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load();
    u_if.JOY_LOAD = 1'b1;
    wait_cyc(4);
    u_if.JOY_LOAD = 1'b0;
    wait_cyc(4);
  endtask

  task automatic do_clk();
    u_if.JOY_CLK = 1'b1;
    wait_cyc(4);
    u_if.JOY_CLK = 1'b0;
    wait_cyc(4);
  endtask

  // Read a frame that is already loaded: bit 31 is visible now, 31 clocks
  // reveal the rest, and a 32nd clock ends the frame.
  task automatic read_rest(output logic [31:0] w);
    w[31] = u_if.JOY_DATA;
    for (int i = 1; i < 32; i++) begin
      do_clk();
      w[31-i] = u_if.JOY_DATA;
    end
    do_clk();
  endtask

  task automatic run_frame(input logic [15:0] a, input logic [15:0] b, output logic [31:0] w);
    j1 = a;
    j2 = b;
    do_load();
    read_rest(w);
  endtask

  typedef struct {
    logic [15:0] j1;
    logic [15:0] j2;
    logic [31:0] wire_word;
  } vec_t;

  vec_t        vecs[5];
  logic [31:0] w;
  logic [31:0] e;

  initial begin
    vecs[0] = '{16'h0011, 16'h8000, 32'hFFEE_7FFF};
    vecs[1] = '{16'h0000, 16'h0000, 32'hFFFF_FFFF};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 32'h0000_0000};
    vecs[3] = '{16'hA5A5, 16'h0F0F, 32'h5A5A_F0F0};
    vecs[4] = '{16'h1234, 16'h8001, 32'hEDCB_7FFE};

    reset = 1'b1;
    j1 = '0;
    j2 = '0;
    u_if.JOY_CLK  = 1'b0;
    u_if.JOY_LOAD = 1'b0;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(1);

    // Reset values.
    check("reset_data",      32'(u_if.JOY_DATA), 32'd1);
    check("reset_done",      32'(frame_done),    32'd0);
    check("reset_err",       32'(frame_err),     32'd0);
    check("reset_link_lost", 32'(link_lost),     32'd0);
    check("reset_state",     32'(dbg_state),     32'd0);

    // A clock edge in IDLE is ignored.
    do_clk();
    check("idle_clk_err",   32'(err_cnt),   32'd0);
    check("idle_clk_state", 32'(dbg_state), 32'd0);

    // Table-driven full frames.
    for (int k = 0; k < 5; k++) begin
      done_cnt = 0;
      err_cnt  = 0;
      exp_q.push_back(vecs[k].wire_word);
      run_frame(vecs[k].j1, vecs[k].j2, w);
      e = exp_q.pop_front();
      check($sformatf("frame_word_%0d", k), w, e);
      check($sformatf("frame_done_%0d", k), 32'(done_cnt), 32'd1);
      check($sformatf("frame_err_%0d", k),  32'(err_cnt),  32'd0);
      check($sformatf("frame_idle_%0d", k), 32'(u_if.JOY_DATA), 32'd1);
      check($sformatf("frame_state_%0d", k), 32'(dbg_state), 32'd2);
    end

    // Snapshot: an input change mid-frame does not affect this frame.
    done_cnt = 0;
    err_cnt  = 0;
    j1 = 16'h0011;
    j2 = 16'h8000;
    do_load();
    w[31] = u_if.JOY_DATA;
    for (int i = 1; i < 32; i++) begin
      do_clk();
      w[31-i] = u_if.JOY_DATA;
      if (i == 5) j1 = 16'hFFFF;
    end
    do_clk();
    check("snap_word", w, 32'hFFEE_7FFF);
    run_frame(16'hFFFF, 16'h8000, w);
    check("snap_next_word", w, 32'h0000_7FFF);
    check("snap_done", 32'(done_cnt), 32'd2);

    // Overrun: 3 extra clocks after a complete frame.
    err_cnt = 0;
    repeat (3) do_clk();
    check("overrun_err",   32'(err_cnt),        32'd3);
    check("overrun_data",  32'(u_if.JOY_DATA),  32'd1);
    check("overrun_state", 32'(dbg_state),      32'd2);

    // Short frame: load, 10 clocks, load again.
    done_cnt = 0;
    err_cnt  = 0;
    j1 = 16'h1234;
    j2 = 16'h8001;
    do_load();
    repeat (10) do_clk();
    check("short_no_err_yet", 32'(err_cnt), 32'd0);
    run_frame(16'h1234, 16'h8001, w);
    check("short_err",  32'(err_cnt),  32'd1);
    check("short_word", w,             32'hEDCB_7FFE);
    check("short_done", 32'(done_cnt), 32'd1);

    // Collision: load and clock rise together. The shift is dropped.
    done_cnt = 0;
    err_cnt  = 0;
    j1 = 16'h4000;
    j2 = 16'h0001;
    u_if.JOY_LOAD = 1'b1;
    u_if.JOY_CLK  = 1'b1;
    wait_cyc(4);
    u_if.JOY_LOAD = 1'b0;
    u_if.JOY_CLK  = 1'b0;
    wait_cyc(4);
    check("collide_first_bit", 32'(u_if.JOY_DATA), 32'd1);
    read_rest(w);
    check("collide_word", w,             32'hBFFF_FFFE);
    check("collide_err",  32'(err_cnt),  32'd0);
    check("collide_done", 32'(done_cnt), 32'd1);

    // Reset mid-frame after clock 12. Bit 19 of ~{000F,..} is 0.
    j1 = 16'h000F;
    j2 = 16'h0000;
    do_load();
    repeat (12) do_clk();
    check("pre_reset_bit", 32'(u_if.JOY_DATA), 32'd0);
    reset = 1'b1;
    wait_cyc(1);
    check("mid_reset_data",  32'(u_if.JOY_DATA), 32'd1);
    check("mid_reset_state", 32'(dbg_state),     32'd0);
    reset = 1'b0;
    wait_cyc(1);
    done_cnt = 0;
    err_cnt  = 0;
    run_frame(16'h000F, 16'h0000, w);
    check("post_reset_word", w,             32'hFFF0_FFFF);
    check("post_reset_done", 32'(done_cnt), 32'd1);
    check("post_reset_err",  32'(err_cnt),  32'd0);

    // Watchdog: no load for more than 1000 cycles.
    wait_cyc(1100);
`ifdef JOY_DB15_TX_TIMEOUT_EN
    check("wd_link_lost", 32'(link_lost), 32'd1);
    check("wd_state",     32'(dbg_state), 32'd0);
    check("wd_data",      32'(u_if.JOY_DATA), 32'd1);
    do_load();
    check("wd_cleared",   32'(link_lost), 32'd0);
    check("wd_reload",    32'(dbg_state), 32'd1);
`else
    check("wd_link_lost", 32'(link_lost), 32'd0);
    check("wd_state",     32'(dbg_state), 32'd2);
    do_load();
    check("wd_after_load", 32'(link_lost), 32'd0);
    check("wd_reload",     32'(dbg_state), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
